// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped UART transmitter with a byte FIFO
//
// Purpose: a CPU store to DATA queues one byte. A serializer sends each
// queued byte as 8N1: one start bit, eight data bits LSB first, one stop bit.
// A load from STATUS returns the FIFO and serializer flags.
//
// Ports:
//   clk        rising-edge clock for all state
//   reset      synchronous active-high reset
//   dataAddr   CPU data address (unmodified CPU output)
//   writeData  CPU store data; only [7:0] is used for DATA, only [3] for STATUS
//   we         one-cycle store strobe
//   readData   STATUS word when STATUS is addressed, otherwise 0
//   mmio_hit   dataAddr falls inside this block's 8-byte window
//   tx         serial output, idle high
//
// Register map (offsets from BASE_ADDR; dataAddr[1:0] ignored):
//   +0 DATA   (write) push writeData[7:0]
//   +4 STATUS {28'b0, overflow, busy, empty, full}; writing bit3=1 clears overflow

module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dataAddr,
  input  logic [31:0] writeData,
  input  logic        we,
  output logic [31:0] readData,
  output logic        mmio_hit,
  output logic        tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_CNT   = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uartState_e;

  uartState_e state, stateNext;

  logic [7:0]    fifoMem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0]   count;
  logic          overflow;

  logic [7:0]    shiftReg, shiftNext;
  logic [CW-1:0] clkCnt, clkCntNext;
  logic [2:0]    bitIdx, bitIdxNext;
  logic          txNext;

  logic isData, isStatus, fifoFull, fifoEmpty, busy;
  logic pushReq, push, pop, overflowSet, overflowClr, bitDone;

  // Low address bits and upper store-data bits carry no meaning here.
  logic unusedBits;
  assign unusedBits = ^{dataAddr[1:0], writeData[31:8]};

  // Address decode and status readback
  assign mmio_hit  = (dataAddr[31:3] == BASE_ADDR[31:3]);
  assign isData    = mmio_hit && !dataAddr[2];
  assign isStatus  = mmio_hit &&  dataAddr[2];

  assign fifoFull  = (count == FULL_COUNT);
  assign fifoEmpty = (count == '0);
  assign busy      = (state != IDLE);

  assign readData  = isStatus ? {28'b0, overflow, busy, fifoEmpty, fifoFull} : 32'b0;

  // FIFO control. A pop frees a slot in the same cycle, so a store to a full
  // FIFO is still accepted when the serializer is taking the head.
  assign pop         = (state == IDLE) && !fifoEmpty;
  assign pushReq     = we && isData && !reset;
  assign push        = pushReq && (!fifoFull || pop);
  assign overflowSet = pushReq && fifoFull && !pop;
  assign overflowClr = we && isStatus && writeData[3];

  assign bitDone = (clkCnt == LAST_CNT);

  // Serializer next-state logic. txNext is what tx shows one cycle later,
  // so every line phase lasts exactly CLKS_PER_BIT cycles of tx.
  always_comb begin
    stateNext  = state;
    clkCntNext = clkCnt;
    bitIdxNext = bitIdx;
    shiftNext  = shiftReg;
    txNext     = 1'b1;
    case (state)
      IDLE: begin
        if (!fifoEmpty) begin
          stateNext  = START;
          shiftNext  = fifoMem[rdPtr];
          clkCntNext = '0;
          bitIdxNext = '0;
        end
      end
      START: begin
        txNext = 1'b0;
        if (bitDone) begin
          stateNext  = DATA;
          clkCntNext = '0;
        end else begin
          clkCntNext = clkCnt + 1'b1;
        end
      end
      DATA: begin
        txNext = shiftReg[0];
        if (bitDone) begin
          clkCntNext = '0;
          if (bitIdx == 3'd7) begin
            stateNext = STOP;
          end else begin
            bitIdxNext = bitIdx + 1'b1;
            shiftNext  = {1'b0, shiftReg[7:1]};
          end
        end else begin
          clkCntNext = clkCnt + 1'b1;
        end
      end
      STOP: begin
        if (bitDone) begin
          stateNext  = IDLE;
          clkCntNext = '0;
          bitIdxNext = '0;
        end else begin
          clkCntNext = clkCnt + 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State, serializer datapath and FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      shiftReg <= '0;
      clkCnt   <= '0;
      bitIdx   <= '0;
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= stateNext;
      tx       <= txNext;
      shiftReg <= shiftNext;
      clkCnt   <= clkCntNext;
      bitIdx   <= bitIdxNext;

      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Set takes priority over a simultaneous clear.
      if (overflowSet) begin
        overflow <= 1'b1;
      end else if (overflowClr) begin
        overflow <= 1'b0;
      end
    end
  end

  // FIFO storage needs no reset: pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem[wrPtr] <= writeData[7:0];
    end
  end

endmodule
